router_output_arbiter: RTL and testbench

//  Wormhole switch allocator for one output port of a mesh Router.

---
 rtl/router_output_arbiter_pkg.sv | 25 ++
 rtl/router_output_arbiter_if.sv | 25 ++
 rtl/router_output_arbiter_rr_arbiter.sv | 29 ++
 rtl/router_output_arbiter.sv | 133 +++++++++++++
 tb/tb_router_output_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/router_output_arbiter_pkg.sv
// Flit-type definitions shared by the Router sub-blocks.
package router_output_arbiter_pkg;

  localparam int TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [TYPE_W-1:0] field);
    return flit_type_e'(field);
  endfunction

  function automatic logic opens_packet(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  function automatic logic closes_packet(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/router_output_arbiter_if.sv
// Flit bus between the input ports, one output arbiter and the downstream link.
interface router_output_arbiter_if #(
  parameter int INPUTS     = 3,
  parameter int DATA_WIDTH = 64
);
  logic [INPUTS*DATA_WIDTH-1:0] data_in_bus;
  logic [INPUTS-1:0]            valid_in_bus;
  logic [INPUTS-1:0]            ready_in_bus;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         valid_out;
  logic                         ready_out;
  logic [INPUTS-1:0]            grant;
  logic                         locked;
  logic                         overrun;

  modport master (
    output data_in_bus, valid_in_bus, ready_out,
    input  ready_in_bus, data_out, valid_out, grant, locked, overrun
  );

  modport slave (
    input  data_in_bus, valid_in_bus, ready_out,
    output ready_in_bus, data_out, valid_out, grant, locked, overrun
  );
endinterface

// File: rtl/router_output_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = PW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Wormhole switch allocator for one Router output: round-robin among HEAD/SINGLE
// requesters, lock from HEAD to TAIL, forced release after FlitPerPacket flits.
module router_output_arbiter
  import router_output_arbiter_pkg::*;
#(
  parameter int INPUTS        = 3,
  parameter int DATA_WIDTH    = 64,
  parameter int TYPE_WIDTH    = 2,
  parameter int FlitPerPacket = 16
) (
  input logic                   clk,
  input logic                   rst,
  router_output_arbiter_if.slave bus
);

  localparam int PW = $clog2(INPUTS);
  localparam int CW = $clog2(FlitPerPacket + 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [CW-1:0]    flit_cnt;
  logic             hold;
  logic             overrun_q;

  logic [INPUTS-1:0] cand;
  logic [INPUTS-1:0] arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;

  logic [PW-1:0]         sel_idx;
  logic                  sel_act;
  logic                  sel_vld;
  logic [INPUTS-1:0]     gnt_vec;
  logic [DATA_WIDTH-1:0] sel_flit;
  flit_type_e            sel_type;
  logic                  xfer;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(INPUTS - 1)) ? '0 : p + PW'(1);
  endfunction

  // Only flits that can open a packet compete for an idle output.
  for (genvar i = 0; i < INPUTS; i++) begin : g_cand
    assign cand[i] = bus.valid_in_bus[i] &&
      opens_packet(flit_type(bus.data_in_bus[i*DATA_WIDTH + DATA_WIDTH-1 -: TYPE_WIDTH]));
  end

  rr_arbiter #(.N(INPUTS)) u_rr (
    .req (cand),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_idx = owner;
    sel_act = 1'b0;
    gnt_vec = '0;
    if (!rst) begin
      if (state == ST_LOCKED || hold) begin
        sel_act        = 1'b1;
        gnt_vec[owner] = 1'b1;
      end else if (arb_any) begin
        sel_idx = arb_idx;
        sel_act = 1'b1;
        gnt_vec = arb_gnt;
      end
    end
    sel_flit = bus.data_in_bus[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_type = flit_type(sel_flit[DATA_WIDTH-1 -: TYPE_WIDTH]);
    sel_vld  = sel_act && bus.valid_in_bus[sel_idx];
    xfer     = sel_vld && bus.ready_out;

    bus.grant        = gnt_vec;
    bus.valid_out    = sel_vld;
    bus.data_out     = sel_act ? sel_flit : '0;
    bus.ready_in_bus = gnt_vec & {INPUTS{bus.ready_out}};
    bus.locked       = !rst && (state == ST_LOCKED);
    bus.overrun      = !rst && overrun_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      flit_cnt  <= '0;
      hold      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            hold   <= 1'b0;
            rr_ptr <= next_ptr(sel_idx);
            if (sel_type == FLIT_HEAD) begin
              state    <= ST_LOCKED;
              owner    <= sel_idx;
              flit_cnt <= CW'(1);
            end
          end else if (sel_vld) begin
            // Stalled winner keeps the grant so a later higher-priority HEAD cannot steal it.
            hold  <= 1'b1;
            owner <= sel_idx;
          end else begin
            hold <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (xfer) begin
            if (closes_packet(sel_type)) begin
              state    <= ST_IDLE;
              flit_cnt <= '0;
            end else if (flit_cnt == CW'(FlitPerPacket - 1)) begin
              state     <= ST_IDLE;
              flit_cnt  <= '0;
              overrun_q <= 1'b1;
            end else begin
              flit_cnt <= flit_cnt + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: vector table, directed wormhole sequences, random traffic vs. reference model.
module tb_router_output_arbiter;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int FPP = 16;
  localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, S = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  router_output_arbiter_if #(.INPUTS(N), .DATA_WIDTH(DW)) bus ();

  router_output_arbiter #(
    .INPUTS(N), .DATA_WIDTH(DW), .TYPE_WIDTH(2), .FlitPerPacket(FPP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        vld [N];
  logic [1:0]  typ [N];
  logic [55:0] tg  [N];
  logic        rdy;
  logic        acc [N];

  // Reference model: packet owner (-1 none), held winner (-1 none), pointer, flit count.
  int m_owner = -1;
  int m_held  = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_ovr   = 1'b0;

  function automatic logic [63:0] mk(input int i, input logic [1:0] t, input logic [55:0] g);
    return {t, 6'(i), g};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.valid_in_bus[i]          = vld[i];
      bus.data_in_bus[i*DW +: DW]  = mk(i, typ[i], tg[i]);
    end
    bus.ready_out = rdy;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] in_type(input int j);
    return bus.data_in_bus[j*DW + DW-2 +: 2];
  endfunction

  function automatic int model_pick();
    if (rst) return -1;
    if (m_owner >= 0) return m_owner;
    if (m_held >= 0) return m_held;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (bus.valid_in_bus[j] && (in_type(j) == H || in_type(j) == S)) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_update
    int g;
    bit ev;
    logic [1:0] t;
    if (rst) begin
      m_owner = -1; m_held = -1; m_ptr = 0; m_cnt = 0; m_ovr = 1'b0;
    end else begin
      g  = model_pick();
      ev = (g >= 0) && bus.valid_in_bus[g];
      t  = (g >= 0) ? in_type(g) : 2'b00;
      m_ovr = 1'b0;
      if (m_owner >= 0) begin
        if (ev && bus.ready_out) begin
          m_cnt++;
          if (t == T || t == S) m_owner = -1;
          else if (m_cnt == FPP) begin
            m_ovr = 1'b1;
            m_owner = -1;
          end
        end
      end else if (ev && bus.ready_out) begin
        m_held = -1;
        m_ptr  = (g + 1) % N;
        if (t == H) begin
          m_owner = g;
          m_cnt   = 1;
        end
      end else begin
        m_held = ev ? g : -1;
      end
    end
  end

  task automatic model_check();
    int g;
    logic [2:0]  eg;
    logic        ev;
    logic [63:0] ed;
    logic [2:0]  er;
    g  = model_pick();
    eg = (g >= 0) ? 3'(1 << g) : 3'b000;
    ev = (g >= 0) && bus.valid_in_bus[g];
    ed = (g >= 0) ? bus.data_in_bus[g*DW +: DW] : 64'd0;
    er = (g >= 0 && bus.ready_out) ? eg : 3'b000;
    check("grant", 64'(bus.grant), 64'(eg));
    check("valid_out", 64'(bus.valid_out), 64'(ev));
    check("data_out", bus.data_out, ed);
    check("ready_in_bus", 64'(bus.ready_in_bus), 64'(er));
    check("locked", 64'(bus.locked), 64'(!rst && m_owner >= 0));
    check("overrun", 64'(bus.overrun), 64'(!rst && m_ovr));
    for (int i = 0; i < N; i++) acc[i] = bus.valid_in_bus[i] && er[i];
  endtask

  task automatic step(input logic r_st, input logic [2:0] v, input logic [1:0] a,
                      input logic [1:0] b, input logic [1:0] c, input logic r,
                      input logic [2:0] eg);
    @(posedge clk);
    #1;
    rst = r_st;
    vld[0] = v[0]; vld[1] = v[1]; vld[2] = v[2];
    typ[0] = a;    typ[1] = b;    typ[2] = c;
    rdy = r;
    drive();
    @(negedge clk);
    model_check();
    check("step_grant", 64'(bus.grant), 64'(eg));
  endtask

  typedef struct {
    logic       r_st;
    logic [2:0] vin;
    logic [1:0] t0, t1, t2;
    logic       rdy;
    logic [2:0] eg;
    logic       ev;
    logic [2:0] er;
    logic       el;
  } vec_t;

  vec_t vt [12];

  initial begin
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; typ[i] = H; tg[i] = 56'(64'h1000 + i); acc[i] = 1'b0;
    end
    rdy = 1'b0;
    drive();

    vt[0]  = '{1'b1, 3'b111, H, H, H, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0};
    vt[1]  = '{1'b1, 3'b111, H, H, H, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0};
    vt[2]  = '{1'b0, 3'b111, S, S, S, 1'b1, 3'b001, 1'b1, 3'b001, 1'b0};
    vt[3]  = '{1'b0, 3'b111, S, S, S, 1'b1, 3'b010, 1'b1, 3'b010, 1'b0};
    vt[4]  = '{1'b0, 3'b111, S, S, S, 1'b1, 3'b100, 1'b1, 3'b100, 1'b0};
    vt[5]  = '{1'b0, 3'b111, S, S, S, 1'b1, 3'b001, 1'b1, 3'b001, 1'b0};
    vt[6]  = '{1'b0, 3'b111, S, S, S, 1'b1, 3'b010, 1'b1, 3'b010, 1'b0};
    vt[7]  = '{1'b0, 3'b000, H, H, H, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0};
    vt[8]  = '{1'b0, 3'b011, B, T, H, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0};
    vt[9]  = '{1'b0, 3'b011, S, H, H, 1'b0, 3'b001, 1'b1, 3'b000, 1'b0};
    vt[10] = '{1'b0, 3'b011, S, H, H, 1'b1, 3'b001, 1'b1, 3'b001, 1'b0};
    vt[11] = '{1'b0, 3'b000, H, H, H, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0};

    for (int k = 0; k < 12; k++) begin
      step(vt[k].r_st, vt[k].vin, vt[k].t0, vt[k].t1, vt[k].t2, vt[k].rdy, vt[k].eg);
      check($sformatf("vec%0d_valid", k), 64'(bus.valid_out), 64'(vt[k].ev));
      check($sformatf("vec%0d_ready", k), 64'(bus.ready_in_bus), 64'(vt[k].er));
      check($sformatf("vec%0d_locked", k), 64'(bus.locked), 64'(vt[k].el));
    end

    // Wormhole: input1 owns the output for four flits despite competing HEADs.
    step(0, 3'b111, H, H, H, 1, 3'b010); check("wh_lock0", 64'(bus.locked), 64'd0);
    step(0, 3'b111, H, B, H, 1, 3'b010); check("wh_lock1", 64'(bus.locked), 64'd1);
    step(0, 3'b111, H, B, H, 1, 3'b010); check("wh_lock2", 64'(bus.locked), 64'd1);
    step(0, 3'b111, H, T, H, 1, 3'b010); check("wh_lock3", 64'(bus.locked), 64'd1);
    step(0, 3'b101, H, B, H, 1, 3'b100); check("wh_next_lock", 64'(bus.locked), 64'd0);
    step(0, 3'b101, H, B, T, 1, 3'b100);
    step(0, 3'b001, H, B, B, 1, 3'b001);
    step(0, 3'b001, T, B, B, 1, 3'b001); check("wh_in0_lock", 64'(bus.locked), 64'd1);

    // Backpressure: grant and data held while stalled, even when input2 would now win.
    step(0, 3'b001, H, B, B, 0, 3'b001); check("bp_data0", bus.data_out, mk(0, H, tg[0]));
    step(0, 3'b101, H, B, H, 0, 3'b001); check("bp_data1", bus.data_out, mk(0, H, tg[0]));
    step(0, 3'b101, H, B, H, 0, 3'b001); check("bp_data2", bus.data_out, mk(0, H, tg[0]));
    step(0, 3'b101, H, B, H, 1, 3'b001); check("bp_valid", 64'(bus.valid_out), 64'd1);
    step(0, 3'b101, T, B, H, 1, 3'b001); check("bp_locked", 64'(bus.locked), 64'd1);

    // Overrun: input2 HEAD + 15 BODY never closes, forced release after the 16th.
    step(0, 3'b101, H, B, H, 1, 3'b100);
    for (int k = 0; k < FPP - 1; k++) begin
      step(0, 3'b101, H, B, B, 1, 3'b100);
      check("ov_quiet", 64'(bus.overrun), 64'd0);
    end
    step(0, 3'b101, H, B, B, 1, 3'b001);
    check("ov_pulse", 64'(bus.overrun), 64'd1);
    check("ov_unlocked", 64'(bus.locked), 64'd0);
    step(0, 3'b101, T, B, B, 1, 3'b001);
    check("ov_single_pulse", 64'(bus.overrun), 64'd0);

    // Reset mid-packet: lock dropped, leftover BODY stalls, new HEAD wins.
    step(0, 3'b010, H, H, B, 1, 3'b010);
    step(0, 3'b010, H, B, B, 1, 3'b010); check("rm_locked", 64'(bus.locked), 64'd1);
    step(1, 3'b011, H, B, B, 1, 3'b000); check("rm_rst_valid", 64'(bus.valid_out), 64'd0);
    check("rm_rst_ready", 64'(bus.ready_in_bus), 64'd0);
    step(0, 3'b011, H, B, B, 1, 3'b001); check("rm_unlocked", 64'(bus.locked), 64'd0);
    check("rm_stall1", 64'(bus.ready_in_bus[1]), 64'd0);
    step(0, 3'b011, T, B, B, 1, 3'b001);
    step(0, 3'b010, H, B, B, 1, 3'b000);

    // Random traffic: each upstream holds its flit until accepted.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(79) == 0);
      for (int i = 0; i < N; i++) begin
        if (!vld[i] || acc[i]) begin
          int r;
          r = $urandom_range(99);
          vld[i] = 1'($urandom_range(1));
          typ[i] = (r < 30) ? H : (r < 60) ? B : (r < 85) ? T : S;
          tg[i]  = 56'({$urandom(), $urandom()});
        end
      end
      rdy = ($urandom_range(99) < 70);
      drive();
      @(negedge clk);
      model_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
